vga_frame_monitor: RTL
======================

# vga_frame_monitor

Passive VGA sink that samples the `HS`, `VS` and `rgb` outputs of the display top level on the same `clk_fpga` domain. It recovers pixel and line position from the sync edges, measures line and frame timing, and locks when that timing matches the expected 640x480 mode. Once per frame it reports a pixel checksum and a lit-pixel count. It sits beside the display top in simulation benches and can be built into on-board self-test.

## Interface
- `DIV`, 4: `clk_fpga` cycles per pixel; must be a power of two, 2 or more.
- `H_TOTAL`, 800: pixels per line.
- `H_START`, 144: pixels from the HS falling edge to the first active pixel (sync plus back porch).
- `H_ACTIVE`, 640: active pixels per line.
- `V_TOTAL`, 525: lines per frame.
- `V_START`, 35: lines from the frame start to the first active line.
- `V_ACTIVE`, 480: active lines per frame.

Ports:
- `clk_fpga`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; all state is cleared on the next rising edge.
- `HS`  in  1  horizontal sync, active-low.
- `VS`  in  1  vertical sync, active-low.
- `rgb`  in  8  pixel colour.
- `locked`  out  1  frame timing matches the parameters.
- `frame_done`  out  1  one-cycle pulse; the result outputs below are valid from this cycle.
- `h_clks`  out  13  clock cycles in the last line of the last frame.
- `v_lines`  out  10  lines in the last frame.
- `lit_count`  out  19  active pixels with `rgb != 0` in the last frame.
- `checksum`  out  16  modulo-2^16 sum of active-pixel `rgb` in the last frame.
- `timing_err`  out  1  one-cycle pulse when a frame closes with timing that does not match while `locked` is high.
- `blank_err`  out  1  sticky flag; see Configuration.

## Operation
Input capture and edge detection:
- `HS`, `VS` and `rgb` are registered into stage s1. `HS` and `VS` are registered again into stage s2.
- `hs_fall` is true when s2 is 1 and s1 is 0. `vs_fall` is defined the same way for VS.

Horizontal position (`hclk`, 13 bits):
- `hclk` is 0 in the cycle after `hs_fall` and increments every clock.
- It saturates at 8191.

Vertical position (`vline`, 10 bits):
- `vline` increments on each `hs_fall` and saturates at 1023.
- A `vs_fall` sets `vpend`. The next `hs_fall` (including one in the same cycle as the `vs_fall`) is the frame boundary: it sets `vline` to 0 and clears `vpend`.

Sampling:
- A sample strobe fires when `hclk[log2 DIV-1:0] == DIV/2`.
- Column is `(hclk >> log2 DIV) - H_START`.
- A sample is active when the column is in `[0, H_ACTIVE)` and `vline` is in `[V_START, V_START+V_ACTIVE)`.
- On each active strobe, `rgb` s1 is added to the running sum. If it is non-zero, the running lit count increments.

Per-line check:
- On each `hs_fall`, the line period `hclk+1` is compared with `H_TOTAL*DIV`.
- A mismatch sets `line_bad`, which is cleared at the frame boundary.
- The first `hs_fall` after SEARCH is not checked.

State machine:
- SEARCH (reset state): wait for a frame boundary, then clear the accumulators and go to MEASURE.
- MEASURE, at each frame boundary:
  - latch the results and pulse `frame_done`;
  - the frame is good when `v_lines == V_TOTAL` and `line_bad` is 0;
  - good: go to LOCKED; otherwise stay in MEASURE.
- LOCKED, at each frame boundary:
  - latch the results and pulse `frame_done`;
  - bad frame: pulse `timing_err` and go to MEASURE.
- `locked` is 1 exactly while the state is LOCKED.

Frame results:
- `v_lines` is `vline+1` at the boundary.
- `h_clks` is the period of the last line.
- The accumulators restart from 0 in the same cycle.

## Timing
- Reset values: `locked`, `frame_done`, `timing_err`, `blank_err` are 0; `h_clks`, `v_lines`, `lit_count`, `checksum` are 0.
- Input latency: an input pin change is seen by the edge detector 2 cycles later.
- Frame boundary latency: `frame_done`, `timing_err`, the updated results and the `locked` change all appear 1 cycle after the boundary `hs_fall` cycle.
- `frame_done` never asserts in SEARCH. The first `frame_done` comes one full frame after the first boundary.
- Loss of HS: the counters saturate, `frame_done` stops, and `locked` holds until the next boundary evaluates the frame (`line_bad` gets set).
- Reset mid-frame: SEARCH is re-entered on the next edge and partial accumulators are discarded.

## Configuration
- `VGA_MON_BLANK_CHECK_EN` defined:
  - on any sample strobe that is not active, a non-zero `rgb` sets `blank_err`;
  - `blank_err` is sticky until `reset`;
  - the check runs only in MEASURE and LOCKED.
- Not defined: `blank_err` is tied to 0 and no checking logic is built.

## Test plan
- Ideal 640x480 generator (DIV 4) with all-zero rgb, 3 frames → first `frame_done` after frame 2 starts; `h_clks`=3200, `v_lines`=525, `lit_count`=0, `checksum`=0; `locked`=1 after the first `frame_done`.
- Same generator, `rgb`=8'h01 on every active pixel → `lit_count`=307200, `checksum`=16'hB000 (307200 mod 65536).
- Locked stream, one line shortened to 799 pixels → `timing_err` pulse at the frame end, `locked`=0, `locked`=1 again after the next clean frame.
- Frame with 524 lines → `v_lines`=524, no lock from MEASURE; from LOCKED, a `timing_err` pulse.
- `reset` pulsed mid-frame while locked → `locked`=0 next cycle, results 0, re-lock after two further boundaries.
- With the macro defined, `rgb`=8'hFF at column -1 of line 100 → `blank_err`=1 and it stays 1; without the macro, `blank_err` stays 0.

Source files
------------

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
//   Passive VGA sink on the clk_fpga domain. Recovers pixel/line position from
//   the sync edges, measures line and frame timing, locks when the timing
//   matches the configured mode and reports a per-frame pixel checksum and
//   lit-pixel count.
//
// Ports
//   clk_fpga    in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   HS, VS      in   active-low syncs
//   rgb[7:0]    in   pixel colour
//   locked      out  frame timing matches the parameters
//   frame_done  out  one-cycle pulse, results valid from this cycle
//   h_clks      out  clock cycles in the last line of the last frame
//   v_lines     out  lines in the last frame
//   lit_count   out  active pixels with rgb != 0 in the last frame
//   checksum    out  mod-2^16 sum of active-pixel rgb in the last frame
//   timing_err  out  one-cycle pulse, bad frame while locked
//   blank_err   out  sticky non-zero rgb outside the active window
//
// Optional feature: define VGA_MON_BLANK_CHECK_EN to build the blanking
// check; otherwise blank_err is tied to 0.
module vga_frame_monitor #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned H_START  = 144,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned V_START  = 35,
    parameter int unsigned V_ACTIVE = 480
) (
    input  logic        clk_fpga,
    input  logic        reset,
    input  logic        HS,
    input  logic        VS,
    input  logic [7:0]  rgb,
    output logic        locked,
    output logic        frame_done,
    output logic [12:0] h_clks,
    output logic [9:0]  v_lines,
    output logic [18:0] lit_count,
    output logic [15:0] checksum,
    output logic        timing_err,
    output logic        blank_err
);

    localparam int unsigned      DIV_LG    = $clog2(DIV);
    localparam logic [DIV_LG-1:0] STROBE_PH = DIV_LG'(DIV / 2);
    localparam logic [13:0]      LINE_CLKS = 14'(H_TOTAL * DIV);
    localparam logic [13:0]      COL_LO    = 14'(H_START);
    localparam logic [13:0]      COL_HI    = 14'(H_START + H_ACTIVE);
    localparam logic [10:0]      ROW_LO    = 11'(V_START);
    localparam logic [10:0]      ROW_HI    = 11'(V_START + V_ACTIVE);
    localparam logic [10:0]      FRM_LINES = 11'(V_TOTAL);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

    state_e      state_q, state_d;
    logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q;
    logic [7:0]  rgb_s1_q;
    logic [12:0] hclk_q, hclk_d;
    logic [9:0]  vline_q, vline_d;
    logic        vpend_q, vpend_d;
    logic        line_bad_q, line_bad_d;
    logic [15:0] sum_q, sum_d;
    logic [18:0] lit_q, lit_d;
    logic        frame_done_q, frame_done_d;
    logic        timing_err_q, timing_err_d;
    logic [12:0] h_clks_q;
    logic [9:0]  v_lines_q;
    logic [18:0] lit_count_q;
    logic [15:0] checksum_q;

    logic        hs_fall, vs_fall, boundary, line_mis, frame_good;
    logic        strobe, col_ok, row_ok, sample_act;
    logic [12:0] pix_col;
    logic [10:0] vlines_now;

    assign hs_fall  = hs_s2_q & ~hs_s1_q;
    assign vs_fall  = vs_s2_q & ~vs_s1_q;
    // A VS fall only arms the boundary; the frame actually starts on the
    // next HS fall, which may be in the same cycle.
    assign boundary = hs_fall & (vpend_q | vs_fall);

    // Lines closing while still in SEARCH carry an arbitrary start point.
    assign line_mis   = hs_fall && (state_q != SEARCH) &&
                        (({1'b0, hclk_q} + 14'd1) != LINE_CLKS);
    assign vlines_now = {1'b0, vline_q} + 11'd1;
    assign frame_good = (vlines_now == FRM_LINES) && !line_bad_q && !line_mis;

    assign strobe     = (hclk_q[DIV_LG-1:0] == STROBE_PH);
    assign pix_col    = hclk_q >> DIV_LG;
    assign col_ok     = ({1'b0, pix_col} >= COL_LO) && ({1'b0, pix_col} < COL_HI);
    assign row_ok     = ({1'b0, vline_q} >= ROW_LO) && ({1'b0, vline_q} < ROW_HI);
    assign sample_act = strobe && col_ok && row_ok;

    always_comb begin
        hclk_d     = hclk_q;
        vline_d    = vline_q;
        vpend_d    = vpend_q;
        line_bad_d = line_bad_q;
        sum_d      = sum_q;
        lit_d      = lit_q;

        if (hs_fall) begin
            hclk_d = '0;
        end else if (hclk_q != '1) begin
            hclk_d = hclk_q + 13'd1;
        end

        if (boundary) begin
            vline_d    = '0;
            vpend_d    = 1'b0;
            line_bad_d = 1'b0;
            sum_d      = '0;
            lit_d      = '0;
        end else begin
            if (hs_fall && vline_q != '1) vline_d = vline_q + 10'd1;
            if (vs_fall)                  vpend_d = 1'b1;
            if (line_mis)                 line_bad_d = 1'b1;
            if (sample_act) begin
                sum_d = sum_q + {8'd0, rgb_s1_q};
                if (rgb_s1_q != '0) lit_d = lit_q + 19'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        timing_err_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (boundary) state_d = MEASURE;
            end
            MEASURE: begin
                if (boundary) begin
                    frame_done_d = 1'b1;
                    if (frame_good) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (boundary) begin
                    frame_done_d = 1'b1;
                    if (!frame_good) begin
                        timing_err_d = 1'b1;
                        state_d      = MEASURE;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q      <= SEARCH;
            hs_s1_q      <= 1'b0;
            hs_s2_q      <= 1'b0;
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            rgb_s1_q     <= '0;
            hclk_q       <= '0;
            vline_q      <= '0;
            vpend_q      <= 1'b0;
            line_bad_q   <= 1'b0;
            sum_q        <= '0;
            lit_q        <= '0;
            frame_done_q <= 1'b0;
            timing_err_q <= 1'b0;
            h_clks_q     <= '0;
            v_lines_q    <= '0;
            lit_count_q  <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            hs_s1_q      <= HS;
            hs_s2_q      <= hs_s1_q;
            vs_s1_q      <= VS;
            vs_s2_q      <= vs_s1_q;
            rgb_s1_q     <= rgb;
            hclk_q       <= hclk_d;
            vline_q      <= vline_d;
            vpend_q      <= vpend_d;
            line_bad_q   <= line_bad_d;
            sum_q        <= sum_d;
            lit_q        <= lit_d;
            frame_done_q <= frame_done_d;
            timing_err_q <= timing_err_d;
            if (frame_done_d) begin
                h_clks_q    <= hclk_q + 13'd1;
                v_lines_q   <= vline_q + 10'd1;
                lit_count_q <= lit_q;
                checksum_q  <= sum_q;
            end
        end
    end

`ifdef VGA_MON_BLANK_CHECK_EN
    logic blank_err_q, blank_err_d;

    always_comb begin
        blank_err_d = blank_err_q;
        if (strobe && !(col_ok && row_ok) && rgb_s1_q != '0 && state_q != SEARCH)
            blank_err_d = 1'b1;
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) blank_err_q <= 1'b0;
        else       blank_err_q <= blank_err_d;
    end

    assign blank_err = blank_err_q;
`else
    assign blank_err = 1'b0;
`endif

    assign locked     = (state_q == LOCKED);
    assign frame_done = frame_done_q;
    assign timing_err = timing_err_q;
    assign h_clks     = h_clks_q;
    assign v_lines    = v_lines_q;
    assign lit_count  = lit_count_q;
    assign checksum   = checksum_q;

endmodule
